// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian 3-byte host stream into instruction words,
// writes them to the instruction store from address 0 and holds the CPU until done.
module imem_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 21,
    parameter int DEPTH   = 256
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic [ADDR_W:0]    WORD_COUNT,
    input  logic [7:0]         BYTE_IN,
    input  logic               BYTE_VALID,
    output logic               BYTE_READY,
    output logic               WE,
    output logic [ADDR_W-1:0]  WADDR,
    output logic [INSTR_W-1:0] WDATA,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERROR,
    output logic               CPU_HOLD
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_B0    = 3'd1;
    localparam logic [2:0] S_B1    = 3'd2;
    localparam logic [2:0] S_B2    = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    localparam int              HI_W    = INSTR_W - 16;
    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

    logic [2:0]         state;
    logic [2:0]         nxt;
    logic [ADDR_W:0]    count_q;
    logic [ADDR_W:0]    wcnt_q;
    logic [HI_W-1:0]    b0_q;
    logic [7:0]         b1_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [INSTR_W-1:0] wdata_q;

    logic xfer;
    logic cnt_ok;
    logic can_start;
    logic start_ok;
    logic last;
    logic bad_b0;

    assign xfer      = BYTE_VALID && BYTE_READY;
    assign cnt_ok    = (WORD_COUNT != '0) && (WORD_COUNT <= MAX_CNT);
    assign can_start = (state == S_IDLE) || (state == S_DONE)
                    || (state == S_ERR);
    assign start_ok  = can_start && START && cnt_ok;
    assign last      = (wcnt_q + ONE) == count_q;
    // Top bits of byte0 fall outside the instruction word and must be zero
    assign bad_b0    = BYTE_IN[7:HI_W] != '0;

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (START) nxt = cnt_ok ? S_B0 : S_ERR;
            end
            S_B0: begin
                if (xfer) nxt = bad_b0 ? S_ERR : S_B1;
            end
            S_B1: begin
                if (xfer) nxt = S_B2;
            end
            S_B2: begin
                if (xfer) nxt = S_WRITE;
            end
            S_WRITE: begin
                nxt = last ? S_DONE : S_B0;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
            wcnt_q  <= '0;
        end else if (start_ok) begin
            count_q <= WORD_COUNT;
            wcnt_q  <= '0;
        end else if (state == S_WRITE && !last) begin
            wcnt_q  <= wcnt_q + ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            b0_q <= '0;
            b1_q <= '0;
        end else if (xfer) begin
            if (state == S_B0) b0_q <= BYTE_IN[HI_W-1:0];
            if (state == S_B1) b1_q <= BYTE_IN;
        end
    end

    // Write port registers only change on byte2, so they hold through DONE
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (xfer && state == S_B2) begin
            waddr_q <= wcnt_q[ADDR_W-1:0];
            wdata_q <= {b0_q, b1_q, BYTE_IN};
        end
    end

    assign BYTE_READY = (state == S_B0) || (state == S_B1)
                     || (state == S_B2);
    assign WE         = state == S_WRITE;
    assign WADDR      = waddr_q;
    assign WDATA      = wdata_q;
    assign BUSY       = BYTE_READY || WE;
    assign DONE       = state == S_DONE;
    assign ERROR      = state == S_ERR;
    assign CPU_HOLD   = state != S_DONE;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the 256 x 21-bit instruction store that the fetch path reads combinationally by 8-bit address.
- Receives a byte stream from a host link and packs each 3-byte group into one 21-bit instruction.
- Writes each instruction into the instruction store at sequential addresses starting at 0.
- Holds the CPU in reset until the requested number of words has been written.

Parameters:
ADDR_W, 8, instruction address width
INSTR_W, 21, instruction word width
DEPTH, 256, number of instruction slots (2**ADDR_W)

Ports:
CLK  in  1  single system clock, all logic rising-edge
RST_N  in  1  asynchronous active-low reset
START  in  1  one-cycle pulse; begins a load (honoured only in IDLE, DONE, ERR)
WORD_COUNT  in  9  number of words to load, legal range 1..256; latched on accepted START
BYTE_IN  in  8  stream byte
BYTE_VALID  in  1  BYTE_IN is valid
BYTE_READY  out  1  loader accepts BYTE_IN this cycle
WE  out  1  instruction-store write enable, one cycle per word
WADDR  out  8  write address
WDATA  out  21  write data
BUSY  out  1  load in progress (states B0, B1, B2, WRITE)
DONE  out  1  level; last load completed
ERROR  out  1  level; last load aborted
CPU_HOLD  out  1  CPU reset request; 1 until a load completes

Behaviour:
- Reset (asynchronous, RST_N=0): state IDLE, word counter 0. Outputs: BYTE_READY=0, WE=0, WADDR=0, WDATA=0, BUSY=0, DONE=0, ERROR=0, CPU_HOLD=1.
- A byte transfer occurs on a rising edge where BYTE_VALID=1 and BYTE_READY=1. BYTE_READY is a registered function of state: 1 only in B0, B1, B2.
- Byte order is big-endian: byte0[4:0] gives WDATA[20:16], byte1 gives [15:8], byte2 gives [7:0]. byte0[7:5] must be 000.
- IDLE:
  - START with WORD_COUNT in 1..256: latch count, clear word counter and DONE/ERROR, go to B0.
  - START with WORD_COUNT=0 or >256: go to ERR.
- B0: on transfer, if byte[7:5]!=0 go to ERR; otherwise store the byte and go to B1.
- B1: on transfer, store the byte and go to B2.
- B2: on transfer, store the byte and go to WRITE.
- WRITE (exactly 1 cycle):
  - WE=1, WADDR=word counter, WDATA=assembled word. BYTE_READY=0.
  - If word counter+1 equals the latched count, go to DONE; otherwise increment the word counter and go to B0.
  - Latency: WE is asserted in the cycle after the byte2 transfer edge.
  - Maximum throughput: one word per 4 cycles.
- DONE: DONE=1, CPU_HOLD=0, BUSY=0. WADDR/WDATA hold the last written values.
- ERR: ERROR=1, CPU_HOLD=1, BUSY=0, no writes. Words already written stay in the store.
- START in DONE or ERR behaves as in IDLE and re-asserts CPU_HOLD=1 on the next cycle.
- START while BUSY is ignored; the latched count is unchanged.
- Word counter width is 9 bits. For WORD_COUNT=256 the last write is at WADDR=0xFF; there is no wrap to 0x00.
- BYTE_VALID is ignored outside B0/B1/B2. The stream may stall indefinitely; there is no timeout.
- WE never asserts outside WRITE. WDATA[20:16] is always byte0[4:0].
- RST_N asserted mid-load aborts immediately to reset values. The partially loaded store is not cleared.

Test Plan:
- START, WORD_COUNT=2, bytes 0x17,0x00,0x00,0x03,0x00,0x01 with continuous VALID -> WE pulses at WADDR=0x00 WDATA=21'h170000 and WADDR=0x01 WDATA=21'h030001; DONE=1 and CPU_HOLD=0 after the second WE; 8 cycles from the first transfer to DONE.
- Same stream with BYTE_VALID toggling 1/0 every cycle -> identical writes; no extra WE; BYTE_READY=0 during each WRITE cycle.
- WORD_COUNT=1, byte0=0x20 -> ERROR=1, CPU_HOLD=1, no WE; then START with valid bytes 0x1F,0xFF,0xFF -> WDATA=21'h1FFFFF at WADDR=0, ERROR cleared, DONE=1.
- WORD_COUNT=0 and WORD_COUNT=257 -> ERROR=1 on the next cycle, BUSY never 1.
- WORD_COUNT=256 with an incrementing pattern -> 256 WE pulses, last at WADDR=0xFF; DONE asserts exactly once; WADDR does not wrap to 0.
- RST_N low after the byte1 transfer of word 3 -> outputs at reset values asynchronously; a new START restarts at WADDR=0. A START pulse mid-load (not during reset) is ignored and the count is unchanged.
